// File: rtl/alu_result_stage.sv
// alu_result_stage
// Consumer end of the 6502 ALU. Registers the ALU result (with BCD correction
// in decimal mode), maintains the processor status register P, and feeds
// carry and decimal mode back to the ALU for the next operation.
module alu_result_stage #(
    parameter logic [7:0] RESET_P    = 8'h24,
    parameter bit         CMOS_FLAGS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic [2:0] op,
    input  logic [7:0] result,
    input  logic [7:0] operand,
    input  logic       of,
    input  logic       cout,
    input  logic       hcout,
    input  logic [2:0] flag_cmd,
    input  logic       p_load,
    input  logic [7:0] p_in,
    input  logic       brk_push,
    output logic [7:0] res_out,
    output logic       res_valid,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       carry,
    output logic       dec
);

    typedef enum logic [2:0] {
        OP_ADC    = 3'b000,
        OP_SBC    = 3'b001,
        OP_LOGIC  = 3'b010,
        OP_SHIFT  = 3'b011,
        OP_CMP    = 3'b100,
        OP_BIT    = 3'b101,
        OP_INCDEC = 3'b110,
        OP_PASS   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        FC_NONE = 3'b000,
        FC_CLC  = 3'b001,
        FC_SEC  = 3'b010,
        FC_CLI  = 3'b011,
        FC_SEI  = 3'b100,
        FC_CLV  = 3'b101,
        FC_CLD  = 3'b110,
        FC_SED  = 3'b111
    } flag_cmd_e;

    // Bit positions inside P = {N,V,1,B,D,I,Z,C}
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    // B never lives in the register; bit 5 always reads as one.
    localparam logic [7:0] P_RESET = {RESET_P[7:6], 2'b10, RESET_P[3:0]};

    op_e        op_code;
    flag_cmd_e  fc_code;
    logic [7:0] p_q;
    logic [7:0] p_alu;
    logic [7:0] p_next;
    logic [7:0] res_dec;
    logic [7:0] nz_src;
    logic       dec_adc;
    logic       dec_sbc;
    logic       lo_fix;
    logic       hi_fix;
    logic       c_adc;
    logic       unused_operand;

    assign op_code = op_e'(op);
    assign fc_code = flag_cmd_e'(flag_cmd);

    // Decimal correction applies only to ADC/SBC while P.D is set.
    assign dec_adc = p_q[P_D] && (op_code == OP_ADC);
    assign dec_sbc = p_q[P_D] && (op_code == OP_SBC);

    // BCD correction of the binary ALU result plus the decimal ADC carry.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        res_dec = result;
        c_adc   = cout;
        lo_fix  = 1'b0;
        hi_fix  = 1'b0;
        if (dec_adc) begin
            lo_fix  = hcout || (result[3:0] > 4'd9);
            hi_fix  = cout || (result > 8'h99);
            res_dec = result + (lo_fix ? 8'h06 : 8'h00) + (hi_fix ? 8'h60 : 8'h00);
            c_adc   = cout || (result > 8'h99);
        end else if (dec_sbc) begin
            lo_fix  = !hcout;
            hi_fix  = !cout;
            res_dec = result - (lo_fix ? 8'h06 : 8'h00) - (hi_fix ? 8'h60 : 8'h00);
        end
    end

    // N/Z come from the corrected value on CMOS parts, the raw ALU value on NMOS.
    assign nz_src = CMOS_FLAGS ? res_dec : result;

    // Flag update implied by the completing ALU operation.
    always_comb begin
        p_alu = p_q;
        case (op_code)
            OP_ADC, OP_SBC: begin
                p_alu[P_N] = nz_src[7];
                p_alu[P_Z] = (nz_src == 8'h00);
                p_alu[P_V] = of;
                p_alu[P_C] = (op_code == OP_ADC) ? c_adc : cout;
            end
            OP_SHIFT, OP_CMP: begin
                p_alu[P_N] = nz_src[7];
                p_alu[P_Z] = (nz_src == 8'h00);
                p_alu[P_C] = cout;
            end
            OP_LOGIC, OP_INCDEC: begin
                p_alu[P_N] = nz_src[7];
                p_alu[P_Z] = (nz_src == 8'h00);
            end
            OP_BIT: begin
                p_alu[P_N] = operand[7];
                p_alu[P_V] = operand[6];
                p_alu[P_Z] = (result == 8'h00);
            end
            default: begin
                p_alu = p_q;
            end
        endcase
    end

    // Next P by priority: P_LOAD, then ALU flags, then a single-bit flag command.
    always_comb begin
        p_next = p_q;
        if (p_load) begin
            p_next = p_in;
        end else if (alu_valid) begin
            p_next = p_alu;
        end else begin
            case (fc_code)
                FC_CLC:  p_next[P_C] = 1'b0;
                FC_SEC:  p_next[P_C] = 1'b1;
                FC_CLI:  p_next[P_I] = 1'b0;
                FC_SEI:  p_next[P_I] = 1'b1;
                FC_CLV:  p_next[P_V] = 1'b0;
                FC_CLD:  p_next[P_D] = 1'b0;
                FC_SED:  p_next[P_D] = 1'b1;
                default: p_next = p_q;
            endcase
        end
        p_next[P_B] = 1'b0;
        p_next[P_U] = 1'b1;
    end

    // Result and status registers; reset drops any result in flight.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            p_q       <= P_RESET;
            res_out   <= 8'h00;
            res_valid <= 1'b0;
        end else begin
            p_q       <= p_next;
            res_valid <= alu_valid;
            if (alu_valid) begin
                res_out <= res_dec;
            end
        end
    end

    assign p_out  = p_q;
    assign p_push = {p_q[P_N], p_q[P_V], 1'b1, brk_push, p_q[P_D], p_q[P_I], p_q[P_Z], p_q[P_C]};
    assign carry  = p_q[P_C];
    assign dec    = p_q[P_D];

    // Only bits 7/6 of the memory operand matter (BIT).
    assign unused_operand = ^operand[5:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
// Scoreboarded bench: each driven cycle pushes the expected result/P from a
// small reference model; the value is popped and compared after the edge.
module tb_alu_result_stage;

    localparam logic [2:0] ADC = 3'd0, SBC = 3'd1, LOGIC = 3'd2, SHIFT = 3'd3;
    localparam logic [2:0] CMP = 3'd4, BIT = 3'd5, INCDEC = 3'd6, PASS = 3'd7;
    localparam logic [2:0] NONE = 3'd0, CLC = 3'd1, SEC = 3'd2, CLI = 3'd3;
    localparam logic [2:0] SEI = 3'd4, CLV = 3'd5, CLD = 3'd6, SED = 3'd7;

    typedef struct {
        logic       av;
        logic [2:0] op;
        logic [7:0] r;
        logic [7:0] opd;
        logic       ofl;
        logic       co;
        logic       hco;
        logic [2:0] fc;
        logic       pl;
        logic [7:0] pin;
    } stim_t;

    typedef struct {
        logic       v;
        logic [7:0] res;
        logic [7:0] p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid;
    logic [2:0] op;
    logic [7:0] result;
    logic [7:0] operand;
    logic       of;
    logic       cout;
    logic       hcout;
    logic [2:0] flag_cmd;
    logic       p_load;
    logic [7:0] p_in;
    logic       brk_push;
    logic [7:0] res_out;
    logic       res_valid;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry;
    logic       dec;

    logic [7:0] n_res_out;
    logic       n_res_valid;
    logic [7:0] n_p_out;
    logic [7:0] n_unused_push;
    logic       n_unused_carry;
    logic       n_unused_dec;

    exp_t       sb[$];
    logic [7:0] m_p;
    logic [7:0] m_res;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .op(op), .result(result),
        .operand(operand), .of(of), .cout(cout), .hcout(hcout), .flag_cmd(flag_cmd),
        .p_load(p_load), .p_in(p_in), .brk_push(brk_push), .res_out(res_out),
        .res_valid(res_valid), .p_out(p_out), .p_push(p_push), .carry(carry), .dec(dec)
    );

    alu_result_stage #(.CMOS_FLAGS(1'b0)) dut_nmos (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .op(op), .result(result),
        .operand(operand), .of(of), .cout(cout), .hcout(hcout), .flag_cmd(flag_cmd),
        .p_load(p_load), .p_in(p_in), .brk_push(brk_push), .res_out(n_res_out),
        .res_valid(n_res_valid), .p_out(n_p_out), .p_push(n_unused_push),
        .carry(n_unused_carry), .dec(n_unused_dec)
    );

    // Reference model of one clock edge (CMOS flag behaviour).
    function automatic exp_t model(input stim_t s, input logic [7:0] p_cur, input logic [7:0] res_cur);
        exp_t       e;
        int         sum;
        logic [7:0] r;
        logic       c_adc;
        sum   = int'(s.r);
        c_adc = s.co;
        if (p_cur[3] && s.op == ADC) begin
            if (s.hco || s.r[3:0] > 4'd9) sum += 6;
            if (s.co || s.r > 8'h99) sum += 'h60;
            c_adc = s.co | (s.r > 8'h99);
        end else if (p_cur[3] && s.op == SBC) begin
            if (!s.hco) sum -= 6;
            if (!s.co) sum -= 'h60;
        end
        r     = sum[7:0];
        e.v   = s.av;
        e.res = s.av ? r : res_cur;
        e.p   = p_cur;
        if (s.pl) begin
            e.p = s.pin;
        end else if (s.av) begin
            case (s.op)
                ADC:           begin e.p[7] = r[7]; e.p[1] = (r == 0); e.p[6] = s.ofl; e.p[0] = c_adc; end
                SBC:           begin e.p[7] = r[7]; e.p[1] = (r == 0); e.p[6] = s.ofl; e.p[0] = s.co; end
                SHIFT, CMP:    begin e.p[7] = r[7]; e.p[1] = (r == 0); e.p[0] = s.co; end
                LOGIC, INCDEC: begin e.p[7] = r[7]; e.p[1] = (r == 0); end
                BIT:           begin e.p[7] = s.opd[7]; e.p[6] = s.opd[6]; e.p[1] = (s.r == 0); end
                default:       ;
            endcase
        end else begin
            case (s.fc)
                CLC: e.p[0] = 1'b0;
                SEC: e.p[0] = 1'b1;
                CLI: e.p[2] = 1'b0;
                SEI: e.p[2] = 1'b1;
                CLV: e.p[6] = 1'b0;
                CLD: e.p[3] = 1'b0;
                SED: e.p[3] = 1'b1;
                default: ;
            endcase
        end
        e.p[5] = 1'b1;
        e.p[4] = 1'b0;
        return e;
    endfunction

    function automatic stim_t s_alu(input logic [2:0] o, input logic [7:0] r, input logic [7:0] opd,
                                    input logic ofl, input logic co, input logic hco);
        stim_t s;
        s = '{av: 1'b1, op: o, r: r, opd: opd, ofl: ofl, co: co, hco: hco, fc: NONE, pl: 1'b0, pin: 8'h00};
        return s;
    endfunction

    function automatic stim_t s_flag(input logic [2:0] fc);
        stim_t s;
        s = '{av: 1'b0, op: PASS, r: 8'h00, opd: 8'h00, ofl: 1'b0, co: 1'b0, hco: 1'b0, fc: fc, pl: 1'b0, pin: 8'h00};
        return s;
    endfunction

    // Drive one cycle of stimulus and push the model's expectation.
    task automatic drive(input stim_t s);
        exp_t e;
        rst       = 1'b0;
        alu_valid = s.av;
        op        = s.op;
        result    = s.r;
        operand   = s.opd;
        of        = s.ofl;
        cout      = s.co;
        hcout     = s.hco;
        flag_cmd  = s.fc;
        p_load    = s.pl;
        p_in      = s.pin;
        e = model(s, m_p, m_res);
        sb.push_back(e);
        m_p   = e.p;
        m_res = e.res;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; op = PASS; result = 8'h00; operand = 8'h00; of = 1'b0;
        cout = 1'b0; hcout = 1'b0; flag_cmd = NONE; p_load = 1'b0; p_in = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        brk_push = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_p = 8'h24;
        m_res = 8'h00;
        checks++; if (p_out !== 8'h24) begin errors++; $display("FAIL reset_p: got %h expected 24", p_out); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        checks++; if (res_out !== 8'h00) begin errors++; $display("FAIL reset_res: got %h expected 00", res_out); end
        checks++; if ({carry, dec} !== 2'b00) begin errors++; $display("FAIL reset_carry_dec: got %b%b expected 00", carry, dec); end
        checks++; if (p_push !== 8'h24) begin errors++; $display("FAIL reset_push: got %h expected 24", p_push); end
    endtask

    task automatic test_flag_cmds;
        stim_t tbl[7];
        exp_t  e;
        tbl = '{s_flag(SED), s_flag(SEC), s_flag(CLI), s_flag(SEI), s_flag(CLV), s_flag(NONE), s_flag(CLD)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin
                errors++;
                $display("FAIL flag_cmd[%0d]: got v=%b res=%h p=%h expected v=%b res=%h p=%h", i, res_valid, res_out, p_out, e.v, e.res, e.p);
            end
            if (i == 5) begin
                checks++;
                if ({carry, dec, p_out} !== {2'b11, 8'h2D}) begin errors++; $display("FAIL flag_carry_dec: got c=%b d=%b p=%h expected c=1 d=1 p=2D", carry, dec, p_out); end
            end
        end
    endtask

    task automatic test_decimal;
        stim_t tbl[8];
        exp_t  e;
        tbl = '{s_flag(SED), s_flag(CLC),
                s_alu(ADC, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0),
                s_alu(ADC, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0),
                s_alu(SBC, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0),
                s_alu(ADC, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1),
                s_alu(ADC, 8'hA0, 8'h00, 1'b1, 1'b0, 1'b0),
                s_alu(SBC, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin
                errors++;
                $display("FAIL decimal[%0d]: got v=%b res=%h p=%h expected v=%b res=%h p=%h", i, res_valid, res_out, p_out, e.v, e.res, e.p);
            end
            if (i == 2) begin
                checks++;
                if ({res_out, p_out[7], p_out[1], p_out[0]} !== {8'h14, 3'b000}) begin errors++; $display("FAIL adc_bcd_0e: got res=%h nzc=%b%b%b expected res=14 nzc=000", res_out, p_out[7], p_out[1], p_out[0]); end
            end
            if (i == 3) begin
                checks++;
                if ({res_out, p_out[1], p_out[0], carry} !== {8'h00, 3'b111}) begin errors++; $display("FAIL adc_bcd_wrap: got res=%h z=%b c=%b carry=%b expected res=00 z=1 c=1 carry=1", res_out, p_out[1], p_out[0], carry); end
                checks++;
                if ({n_res_valid, n_res_out, n_p_out[1], n_p_out[0]} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin errors++; $display("FAIL nmos_wrap: got v=%b res=%h z=%b c=%b expected v=1 res=00 z=0 c=1", n_res_valid, n_res_out, n_p_out[1], n_p_out[0]); end
            end
            if (i == 4) begin
                checks++;
                if ({res_out, p_out[7], p_out[0]} !== {8'h99, 2'b10}) begin errors++; $display("FAIL sbc_bcd: got res=%h n=%b c=%b expected res=99 n=1 c=0", res_out, p_out[7], p_out[0]); end
            end
        end
    endtask

    task automatic test_binary;
        stim_t tbl[8];
        exp_t  e;
        tbl = '{s_alu(LOGIC, 8'h0E, 8'h00, 1'b0, 1'b1, 1'b1),
                s_flag(CLD),
                s_alu(ADC, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0),
                s_alu(LOGIC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0),
                s_alu(SHIFT, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0),
                s_alu(INCDEC, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0),
                s_alu(CMP, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0),
                s_alu(SBC, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin
                errors++;
                $display("FAIL binary[%0d]: got v=%b res=%h p=%h expected v=%b res=%h p=%h", i, res_valid, res_out, p_out, e.v, e.res, e.p);
            end
        end
    endtask

    task automatic test_bit_pass;
        stim_t      tbl[3];
        stim_t      pass_sec;
        exp_t       e;
        logic [7:0] p_before;
        pass_sec    = s_alu(PASS, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b1);
        pass_sec.fc = SEC;
        tbl = '{s_flag(CLC), s_alu(BIT, 8'h00, 8'hC0, 1'b0, 1'b1, 1'b0), pass_sec};
        foreach (tbl[i]) begin
            p_before = p_out;
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin
                errors++;
                $display("FAIL bit_pass[%0d]: got v=%b res=%h p=%h expected v=%b res=%h p=%h", i, res_valid, res_out, p_out, e.v, e.res, e.p);
            end
            if (i == 1) begin
                checks++;
                if ({p_out[7:6], p_out[1], p_out[0]} !== 4'b1110) begin errors++; $display("FAIL bit_flags: got nvzc=%b%b%b%b expected 1110", p_out[7], p_out[6], p_out[1], p_out[0]); end
            end
            if (i == 2) begin
                checks++;
                if ({res_out, p_out} !== {8'h5A, p_before}) begin errors++; $display("FAIL pass_no_flags: got res=%h p=%h expected res=5A p=%h", res_out, p_out, p_before); end
            end
        end
    endtask

    task automatic test_priority;
        stim_t s;
        exp_t  e;
        s     = s_alu(CMP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        s.pl  = 1'b1;
        s.pin = 8'hFF;
        s.fc  = CLC;
        brk_push = 1'b1;
        drive(s);
        e = sb.pop_front();
        checks++;
        if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin errors++; $display("FAIL prio_model: got v=%b res=%h p=%h expected v=%b res=%h p=%h", res_valid, res_out, p_out, e.v, e.res, e.p); end
        checks++;
        if ({p_out, res_valid, p_push} !== {8'hEF, 1'b1, 8'hFF}) begin errors++; $display("FAIL prio_load: got p=%h v=%b push=%h expected p=EF v=1 push=FF", p_out, res_valid, p_push); end
        brk_push = 1'b0;
        #1;
        checks++;
        if (p_push !== 8'hEF) begin errors++; $display("FAIL push_brk0: got %h expected EF", p_push); end
        s    = s_alu(LOGIC, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        s.fc = CLC;
        drive(s);
        e = sb.pop_front();
        checks++;
        if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin errors++; $display("FAIL prio_alu_over_cmd: got v=%b res=%h p=%h expected v=%b res=%h p=%h", res_valid, res_out, p_out, e.v, e.res, e.p); end
        s     = s_flag(SED);
        s.pl  = 1'b1;
        s.pin = 8'h10;
        drive(s);
        e = sb.pop_front();
        checks++;
        if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin errors++; $display("FAIL prio_load_over_cmd: got v=%b res=%h p=%h expected v=%b res=%h p=%h", res_valid, res_out, p_out, e.v, e.res, e.p); end
    endtask

    task automatic test_back_to_back;
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 40; i++) begin
            s     = s_alu(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            s.fc  = 3'($urandom_range(0, 7));
            s.pl  = ($urandom_range(0, 7) == 0);
            s.pin = 8'($urandom);
            drive(s);
            e = sb.pop_front();
            checks++;
            if ({res_valid, res_out, p_out} !== {e.v, e.res, e.p}) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%b res=%h p=%h expected v=%b res=%h p=%h", i, res_valid, res_out, p_out, e.v, e.res, e.p);
            end
        end
    endtask

    task automatic test_reset_inflight;
        rst       = 1'b1;
        alu_valid = 1'b1;
        op        = ADC;
        result    = 8'h77;
        p_load    = 1'b1;
        p_in      = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        sb.delete();
        m_p   = 8'h24;
        m_res = 8'h00;
        checks++;
        if ({res_valid, res_out, p_out} !== {1'b0, 8'h00, 8'h24}) begin errors++; $display("FAIL reset_inflight: got v=%b res=%h p=%h expected v=0 res=00 p=24", res_valid, res_out, p_out); end
        drive(s_flag(NONE));
        checks++;
        if ({res_valid, p_out} !== {1'b0, 8'h24}) begin errors++; $display("FAIL reset_inflight_after: got v=%b p=%h expected v=0 p=24", res_valid, p_out); end
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        brk_push = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_flag_cmds();
        test_decimal();
        test_binary();
        test_bit_pass();
        test_priority();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
